// File: rtl/sa_golomb_pkg.sv
// Shared types and elaboration-time helpers for the adaptive Golomb encoder.
// Latency: none (package only).
// Backpressure: none (package only).
package sa_golomb_pkg;

  // How the codeword for a captured sample is formed.
  typedef enum logic [1:0] {
    MODE_RAW    = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_ESCAPE = 2'd2
  } cw_mode_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(value)) r++;
    return r;
  endfunction

  // Width of out_len: must represent lengths 0..U_MAX+D_WIDTH.
  function automatic int len_width(input int u_max, input int d_width);
    return clog2(u_max + d_width + 1);
  endfunction

  // Width of k: holds 0..D_WIDTH-2.
  function automatic int k_width(input int d_width);
    return clog2(d_width);
  endfunction

  // Initial accumulator: floor((3*2^(K'+6) - 49) * 2^GAMMA0 / 2^7).
  function automatic longint init_acc(input int k_init, input int gamma0);
    return ((3 * (longint'(1) << (k_init + 6)) - 49) * (longint'(1) << gamma0)) / 128;
  endfunction

endpackage

// File: rtl/sa_golomb_encoder_k_select.sv
// Golomb parameter search: largest k in 0..D_WIDTH-2 with G*2^k <= S + floor(49*G/128).
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
module golomb_k_select
  import sa_golomb_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int GAMMA_STAR = 6
) (
  input  logic [GAMMA_STAR-1:0]         g,
  input  logic [D_WIDTH+GAMMA_STAR-1:0] s,
  output logic [k_width(D_WIDTH)-1:0]   k
);

  localparam int KW = k_width(D_WIDTH);
  // Wide enough for G*2^(D_WIDTH-2), S and 49*G without wrap.
  localparam int CW = D_WIDTH + GAMMA_STAR + 7;

  logic [CW-1:0] g_ext;
  logic [CW-1:0] thresh;

  assign g_ext  = CW'(g);
  assign thresh = CW'(s) + ((g_ext * CW'(49)) >> 7);

  // Scan upward; the condition is monotone so the last hit is the largest k.
  always_comb begin
    k = '0;
    for (int i = 0; i <= D_WIDTH - 2; i++) begin
      if ((g_ext << i) <= thresh) k = KW'(i);
    end
  end

endmodule

// File: rtl/sa_golomb_encoder.sv
// Adaptive sample Golomb encoder: maps residuals to length-limited Golomb codewords.
// Latency: two register stages (S1 delta/k/mode, S2 codeword); one sample per cycle.
// Backpressure: whole pipeline and adaptive state stall while out_valid && !out_ready.
module sa_golomb_encoder
  import sa_golomb_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int U_MAX      = 18,
  parameter int GAMMA0     = 1,
  parameter int GAMMA_STAR = 6,
  parameter int K_INIT     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [D_WIDTH-1:0]                   in_data,
  input  logic                                 in_first,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [U_MAX+D_WIDTH-1:0]             out_data,
  output logic [len_width(U_MAX, D_WIDTH)-1:0] out_len
);

  localparam int GW  = GAMMA_STAR;
  localparam int SW  = D_WIDTH + GAMMA_STAR;
  localparam int OW  = U_MAX + D_WIDTH;
  localparam int LW  = len_width(U_MAX, D_WIDTH);
  localparam int KW  = k_width(D_WIDTH);
  localparam int UCW = D_WIDTH + 6;

  localparam logic [GW-1:0] G_INIT = GW'(longint'(1) << GAMMA0);
  localparam logic [SW-1:0] S_INIT = SW'(init_acc(K_INIT, GAMMA0));
  localparam logic [GW-1:0] G_SAT  = '1;

  logic               en;
  logic               accept;
  logic [GW-1:0]      g_q;
  logic [SW-1:0]      s_q;
  logic [KW-1:0]      k_sel;
  logic [D_WIDTH-1:0] u_in;
  logic               escape_in;
  logic [SW:0]        s_sum;
  logic [SW-1:0]      s_half;
  logic [GW-1:0]      g_half;

  logic               s1_vld;
  logic [D_WIDTH-1:0] s1_delta;
  logic [KW-1:0]      s1_k;
  cw_mode_t           s1_mode;
  logic [D_WIDTH-1:0] s1_u;
  logic [D_WIDTH-1:0] s1_mask;

  logic [OW-1:0]      cw_data;
  logic [LW-1:0]      cw_len;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  golomb_k_select #(
    .D_WIDTH   (D_WIDTH),
    .GAMMA_STAR(GAMMA_STAR)
  ) u_k_select (
    .g(g_q),
    .s(s_q),
    .k(k_sel)
  );

  assign u_in      = in_data >> k_sel;
  assign escape_in = UCW'(u_in) >= UCW'(U_MAX);

  // One spare bit keeps S + delta exact before the halving rescale.
  assign s_sum  = {1'b0, s_q} + (SW+1)'(in_data);
  assign s_half = SW'((s_sum + (SW+1)'(1)) >> 1);
  assign g_half = GW'(({1'b0, g_q} + (GW+1)'(1)) >> 1);

  // S1 capture plus adaptive G/S update on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_delta <= '0;
      s1_k     <= '0;
      s1_mode  <= MODE_RAW;
      g_q      <= G_INIT;
      s_q      <= S_INIT;
    end else if (en) begin
      s1_vld <= accept;
      if (accept) begin
        s1_delta <= in_data;
        s1_k     <= k_sel;
        if (in_first) begin
          s1_mode <= MODE_RAW;
          g_q     <= G_INIT;
          s_q     <= S_INIT;
        end else begin
          s1_mode <= escape_in ? MODE_ESCAPE : MODE_NORMAL;
          if (g_q != G_SAT) begin
            s_q <= s_sum[SW-1:0];
            g_q <= g_q + GW'(1);
          end else begin
            s_q <= s_half;
            g_q <= g_half;
          end
        end
      end
    end
  end

  assign s1_u    = s1_delta >> s1_k;
  assign s1_mask = (D_WIDTH'(1) << s1_k) - D_WIDTH'(1);

  // Codeword assembly from S1; an empty S1 yields an all-zero codeword.
  always_comb begin
    cw_data = '0;
    cw_len  = '0;
    if (s1_vld) begin
      case (s1_mode)
        MODE_RAW: begin
          cw_data = OW'(s1_delta);
          cw_len  = LW'(D_WIDTH);
        end
        MODE_ESCAPE: begin
          cw_data = OW'(s1_delta);
          cw_len  = LW'(OW);
        end
        default: begin
          // Leading unary zeros are implicit above the stop bit.
          cw_data = (OW'(1) << s1_k) | OW'(s1_delta & s1_mask);
          cw_len  = LW'(s1_u) + LW'(s1_k) + LW'(1);
        end
      endcase
    end
  end

  // S2 codeword register drives the output port directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
    end else if (en) begin
      out_valid <= s1_vld;
      out_data  <= cw_data;
      out_len   <= cw_len;
    end
  end

endmodule

// File: tb/tb_sa_golomb_encoder.sv
// Self-checking bench for sa_golomb_encoder with a behavioural scoreboard model.
// Latency: n/a (testbench).
// Backpressure: randomized and directed out_ready stalls.
module tb_sa_golomb_encoder;

  localparam int D      = 16;
  localparam int UM     = 18;
  localparam int OW     = 34;
  localparam int LW     = 6;
  localparam int K_INIT = 4;
  localparam int GAMMA0 = 1;
  localparam int GSTAR  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [D-1:0]  in_data = '0;
  logic          in_first = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [LW-1:0] out_len;

  int n_checks = 0;
  int n_fail   = 0;

  longint        mg, ms;
  logic [OW-1:0] exp_d[$];
  int            exp_l[$];
  logic [OW-1:0] got_d[$];
  int            got_l[$];
  int            ready_mode = 0;
  bit            was_rst = 1'b1;

  always #5 clk = ~clk;

  sa_golomb_encoder #(
    .D_WIDTH(D), .U_MAX(UM), .GAMMA0(GAMMA0), .GAMMA_STAR(GSTAR), .K_INIT(K_INIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_init();
    mg = longint'(1) << GAMMA0;
    ms = ((3 * (longint'(1) << (K_INIT + 6)) - 49) * mg) / 128;
  endfunction

  // Expected codeword and state update for one accepted sample.
  function automatic void model_accept(input logic [D-1:0] d, input bit first);
    longint dl, thr, u;
    int     k;
    dl = longint'(d);
    if (first) begin
      exp_d.push_back(OW'(dl));
      exp_l.push_back(D);
      model_init();
      return;
    end
    thr = ms + (49 * mg) / 128;
    k = 0;
    while (k < D - 2 && (mg << (k + 1)) <= thr) k++;
    u = dl >> k;
    if (u < UM) begin
      exp_d.push_back(OW'((longint'(1) << k) + (dl % (longint'(1) << k))));
      exp_l.push_back(int'(u) + 1 + k);
    end else begin
      exp_d.push_back(OW'(dl));
      exp_l.push_back(UM + D);
    end
    if (mg < (longint'(1) << GSTAR) - 1) begin
      ms = ms + dl;
      mg = mg + 1;
    end else begin
      ms = (ms + dl + 1) / 2;
      mg = (mg + 1) / 2;
    end
  endfunction

  // Compare process: outputs checked mid-cycle, then the coming edge is modelled.
  always @(negedge clk) begin
    if (was_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_len", out_len, 0);
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_d.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("out_data", out_data, exp_d[0]);
          chk("out_len", out_len, exp_l[0]);
        end
      end
    end
    if (rst) begin
      exp_d.delete();
      exp_l.delete();
      model_init();
    end else begin
      if (out_valid && out_ready && exp_d.size() != 0) begin
        got_d.push_back(out_data);
        got_l.push_back(int'(out_len));
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end
      if (in_valid && in_ready) model_accept(in_data, in_first);
    end
    was_rst = rst;
  end

  // Downstream readiness: 0 always ready, 1 random, otherwise stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D-1:0] d, input bit first);
    int guard;
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_first = first;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 500);
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
    in_data  = D'($urandom);
    in_first = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_d.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_empty", exp_d.size(), 0);
  endtask

  initial begin
    logic [D-1:0] dv;
    int r;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // First sample raw, two-edge latency, then a normal codeword.
    got_d.delete(); got_l.delete();
    in_valid = 1'b1; in_data = 16'd37; in_first = 1'b1;
    tick();
    chk("lat_after_accept_edge", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("lat_after_second_edge", out_valid, 1);
    send(16'd37, 1'b0);
    drain();
    chk("a_count", got_d.size(), 2);
    if (got_d.size() >= 2) begin
      chk("a_raw_data", got_d[0], 64'h25);
      chk("a_raw_len", got_l[0], 16);
      chk("a_norm_data", got_d[1], 64'h15);
      chk("a_norm_len", got_l[1], 7);
    end
    chk("a_model_g", mg, 3);
    chk("a_model_s", ms, 84);

    // Escape codeword.
    got_d.delete(); got_l.delete();
    send(16'd0, 1'b1);
    send(16'd1000, 1'b0);
    drain();
    if (got_d.size() >= 2) begin
      chk("b_esc_data", got_d[1], 64'h3E8);
      chk("b_esc_len", got_l[1], 34);
    end else chk("b_count", got_d.size(), 2);

    // Counter saturation and rescale.
    got_d.delete(); got_l.delete();
    send(16'd0, 1'b1);
    repeat (61) send(16'd0, 1'b0);
    chk("c_model_g_sat", mg, 63);
    chk("c_model_s_sat", ms, 47);
    send(16'd0, 1'b0);
    chk("c_model_g_half", mg, 32);
    chk("c_model_s_half", ms, 24);
    send(16'd5, 1'b0);
    drain();
    chk("c_count", got_d.size(), 64);
    if (got_d.size() >= 64) begin
      chk("c_k4_zero_data", got_d[1], 64'h10);
      chk("c_k4_zero_len", got_l[1], 5);
      chk("c_rescale_data", got_d[62], 64'h1);
      chk("c_rescale_len", got_l[62], 1);
      chk("c_after_data", got_d[63], 64'h1);
      chk("c_after_len", got_l[63], 6);
    end

    // Stall with both stages full.
    got_d.delete(); got_l.delete();
    ready_mode = 2;
    tick(); tick();
    send(16'd100, 1'b1);
    send(16'd200, 1'b0);
    in_valid = 1'b1; in_data = 16'd300; in_first = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 64'd100);
    end
    ready_mode = 0;
    send(16'd300, 1'b0);
    drain();
    chk("d_count", got_d.size(), 3);
    if (got_d.size() >= 3) begin
      chk("d_first_data", got_d[0], 64'd100);
      chk("d_second_data", got_d[1], 64'h18);
      chk("d_second_len", got_l[1], 17);
      chk("d_third_data", got_d[2], 64'h6C);
      chk("d_third_len", got_l[2], 11);
    end

    // Reset mid-stream discards both stages and restores G/S.
    ready_mode = 2;
    tick(); tick();
    send(16'd7, 1'b1);
    send(16'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_out_valid_after_rst", out_valid, 0);
    ready_mode = 0;
    got_d.delete(); got_l.delete();
    repeat (10) tick();
    chk("e_no_stale", got_d.size(), 0);
    send(16'd37, 1'b0);
    drain();
    if (got_d.size() >= 1) begin
      chk("e_init_data", got_d[0], 64'h15);
      chk("e_init_len", got_l[0], 7);
    end else chk("e_count", got_d.size(), 1);

    // Randomized traffic with random backpressure and gaps.
    ready_mode = 1;
    send(D'($urandom_range(0, 40)), 1'b1);
    repeat (600) begin
      repeat ($urandom_range(0, 1)) begin
        in_data  = D'($urandom);
        in_first = 1'($urandom);
        tick();
      end
      r = $urandom_range(0, 99);
      if (r < 60)      dv = D'($urandom_range(0, 40));
      else if (r < 85) dv = D'($urandom_range(0, 2000));
      else             dv = D'($urandom);
      send(dv, $urandom_range(0, 49) == 0);
    end
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
